// File: rtl/pulse_channel.sv
// pulse_channel: square-wave voice with duty sequencer, envelope, length counter and sweep.
// Compile-time option PULSE_SWEEP_EN builds the sweep unit; without it reg1 writes are ignored.
module pulse_channel #(
  parameter int CHANNEL = 0,
  parameter int OUT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             quarter_frame,
  input  logic             half_frame,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             enable,
  output logic [OUT_W-1:0] vol,
  output logic             active
);

  if (CHANNEL != 0 && CHANNEL != 1) begin : g_bad_channel
    $error("pulse_channel: CHANNEL must be 0 or 1");
  end

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  logic [1:0]       duty_q, duty_d;
  logic             loop_q, loop_d;
  logic             const_q, const_d;
  logic [3:0]       env_v_q, env_v_d;
  logic [10:0]      period_q, period_d;
  logic [10:0]      timer_q, timer_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       length_q, length_d;
  logic             env_start_q, env_start_d;
  logic [3:0]       env_div_q, env_div_d;
  logic [3:0]       decay_q, decay_d;
  logic [OUT_W-1:0] vol_q, vol_d;

  logic       wr0, wr2, wr3;
  logic       mute;
  logic [7:0] duty_pattern;
  logic       duty_bit;
  logic [3:0] level;

  assign wr0 = wr_en && (wr_addr == 2'd0);
  assign wr2 = wr_en && (wr_addr == 2'd2);
  assign wr3 = wr_en && (wr_addr == 2'd3);

`ifdef PULSE_SWEEP_EN
  logic        wr1;
  logic        sw_en_q, sw_en_d;
  logic [2:0]  sw_p_q, sw_p_d;
  logic        sw_neg_q, sw_neg_d;
  logic [2:0]  sw_shift_q, sw_shift_d;
  logic [2:0]  sw_div_q, sw_div_d;
  logic        sw_reload_q, sw_reload_d;
  logic [10:0] sw_delta;
  logic [11:0] sw_target;

  assign wr1 = wr_en && (wr_addr == 2'd1);

  // Target is one bit wider than the period so an overflowing add can be seen and muted.
  always_comb begin
    sw_delta = period_q >> sw_shift_q;
    if (!sw_neg_q)
      sw_target = {1'b0, period_q} + {1'b0, sw_delta};
    else if (CHANNEL == 1)
      sw_target = {1'b0, period_q} - {1'b0, sw_delta};
    else
      sw_target = {1'b0, period_q} - {1'b0, sw_delta} - 12'd1;
  end

  assign mute = (period_q < 11'd8) || (sw_target > 12'h7FF);
`else
  assign mute = (period_q < 11'd8);
`endif

  always_comb begin
    case (duty_q)
      2'd0:    duty_pattern = 8'b0100_0000;
      2'd1:    duty_pattern = 8'b0110_0000;
      2'd2:    duty_pattern = 8'b0111_1000;
      default: duty_pattern = 8'b1001_1111;
    endcase
  end

  // Step 0 is the leftmost character of the written pattern.
  assign duty_bit = duty_pattern[3'd7 - step_q];
  assign level    = const_q ? env_v_q : decay_q;

  always_comb begin
    duty_d      = duty_q;
    loop_d      = loop_q;
    const_d     = const_q;
    env_v_d     = env_v_q;
    period_d    = period_q;
    timer_d     = timer_q;
    step_d      = step_q;
    length_d    = length_q;
    env_start_d = env_start_q;
    env_div_d   = env_div_q;
    decay_d     = decay_q;
    vol_d       = '0;
`ifdef PULSE_SWEEP_EN
    sw_en_d     = sw_en_q;
    sw_p_d      = sw_p_q;
    sw_neg_d    = sw_neg_q;
    sw_shift_d  = sw_shift_q;
    sw_div_d    = sw_div_q;
    sw_reload_d = sw_reload_q;

    if (half_frame) begin
      if (sw_div_q == 3'd0 && sw_en_q && sw_shift_q != 3'd0 && !mute)
        period_d = sw_target[10:0];
      if (sw_div_q == 3'd0 || sw_reload_q) begin
        sw_div_d    = sw_p_q;
        sw_reload_d = 1'b0;
      end else begin
        sw_div_d = sw_div_q - 3'd1;
      end
    end
    if (wr1) begin
      sw_en_d     = wr_data[7];
      sw_p_d      = wr_data[6:4];
      sw_neg_d    = wr_data[3];
      sw_shift_d  = wr_data[2:0];
      sw_reload_d = 1'b1;
    end
`endif

    if (wr0) begin
      duty_d  = wr_data[7:6];
      loop_d  = wr_data[5];
      const_d = wr_data[4];
      env_v_d = wr_data[3:0];
    end
    // Writes rebuild the period from the old value, so a same-cycle sweep result is discarded.
    if (wr2) period_d = {period_q[10:8], wr_data};
    if (wr3) period_d = {wr_data[2:0], period_q[7:0]};

    if (tick) begin
      if (timer_q == 11'd0) begin
        timer_d = period_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end
    if (wr3) step_d = 3'd0;

    if (quarter_frame) begin
      if (env_start_q) begin
        env_start_d = 1'b0;
        decay_d     = 4'd15;
        env_div_d   = env_v_q;
      end else if (env_div_q == 4'd0) begin
        env_div_d = env_v_q;
        if (decay_q != 4'd0)
          decay_d = decay_q - 4'd1;
        else if (loop_q)
          decay_d = 4'd15;
      end else begin
        env_div_d = env_div_q - 4'd1;
      end
    end
    if (wr3) env_start_d = 1'b1;

    if (half_frame && length_q != 8'd0 && !loop_q) length_d = length_q - 8'd1;
    if (wr3 && enable) length_d = LEN_TABLE[wr_data[7:3]];
    if (!enable) length_d = 8'd0;

    if (!mute && length_q != 8'd0 && duty_bit) vol_d = OUT_W'(level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q      <= 2'd0;
      loop_q      <= 1'b0;
      const_q     <= 1'b0;
      env_v_q     <= 4'd0;
      period_q    <= 11'd0;
      timer_q     <= 11'd0;
      step_q      <= 3'd0;
      length_q    <= 8'd0;
      env_start_q <= 1'b0;
      env_div_q   <= 4'd0;
      decay_q     <= 4'd0;
      vol_q       <= '0;
`ifdef PULSE_SWEEP_EN
      sw_en_q     <= 1'b0;
      sw_p_q      <= 3'd0;
      sw_neg_q    <= 1'b0;
      sw_shift_q  <= 3'd0;
      sw_div_q    <= 3'd0;
      sw_reload_q <= 1'b0;
`endif
    end else begin
      duty_q      <= duty_d;
      loop_q      <= loop_d;
      const_q     <= const_d;
      env_v_q     <= env_v_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      step_q      <= step_d;
      length_q    <= length_d;
      env_start_q <= env_start_d;
      env_div_q   <= env_div_d;
      decay_q     <= decay_d;
      vol_q       <= vol_d;
`ifdef PULSE_SWEEP_EN
      sw_en_q     <= sw_en_d;
      sw_p_q      <= sw_p_d;
      sw_neg_q    <= sw_neg_d;
      sw_shift_q  <= sw_shift_d;
      sw_div_q    <= sw_div_d;
      sw_reload_q <= sw_reload_d;
`endif
    end
  end

  assign vol    = vol_q;
  assign active = (length_q != 8'd0);

endmodule

// File: tb/tb_pulse_channel.sv
// tb_pulse_channel: directed tests for pulse_channel with hand-computed expected values.
module tb_pulse_channel;

  localparam int CHANNEL = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       quarter_frame = 1'b0;
  logic       half_frame = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       enable = 1'b0;
  logic [3:0] vol;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  pulse_channel #(.CHANNEL(CHANNEL), .OUT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .enable        (enable),
    .vol           (vol),
    .active        (active)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc(1);
    wr_en   = 1'b0;
  endtask

  task automatic one_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_qf();
    quarter_frame = 1'b1;
    cyc(1);
    quarter_frame = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_hf();
    half_frame = 1'b1;
    cyc(1);
    half_frame = 1'b0;
    cyc(1);
  endtask

  initial begin
    int hi_cnt;
    logic [3:0] exp_v;

    @(negedge clk);
    do_reset();
    check("reset_vol", 32'(vol), 0);
    check("reset_active", 32'(active), 0);

    // Tone: duty 2, constant 15, period 16 -> high on steps 1..4, 17 ticks per step
    enable = 1'b1;
    write_reg(2'd0, 8'hBF);
    write_reg(2'd2, 8'h10);
    write_reg(2'd3, 8'h08);
    check("tone_active", 32'(active), 1);
    hi_cnt = 0;
    tick = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      cyc(1);
      if (vol == 4'd15) hi_cnt++;
      if (i == 1)   check("tone_e1", 32'(vol), 0);
      if (i == 2)   check("tone_e2", 32'(vol), 15);
      if (i == 69)  check("tone_e69", 32'(vol), 15);
      if (i == 70)  check("tone_e70", 32'(vol), 0);
      if (i == 140) check("tone_e140", 32'(vol), 15);
    end
    tick = 1'b0;
    check("tone_high_count", 32'(hi_cnt), 71);

    // Asynchronous reset mid-tone, checked before the next rising edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vol", 32'(vol), 0);
    check("async_rst_active", 32'(active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check("idle_vol", 32'(vol), 0);
    check("idle_active", 32'(active), 0);

    // Envelope decay 15..0, hold, then loop wrap
    write_reg(2'd0, 8'h00);
    write_reg(2'd2, 8'h10);
    write_reg(2'd3, 8'h08);
    one_tick();
    check("env_pre_start", 32'(vol), 0);
    for (int k = 1; k <= 16; k++) begin
      pulse_qf();
      check($sformatf("env_decay_%0d", k), 32'(vol), 32'(16 - k));
    end
    pulse_qf();
    check("env_hold0", 32'(vol), 0);
    write_reg(2'd0, 8'h20);
    pulse_qf();
    check("env_loop_wrap", 32'(vol), 15);

    // reg3 write on a quarter_frame: start stays pending for the next strobe
    write_reg(2'd0, 8'h00);
    quarter_frame = 1'b1;
    write_reg(2'd3, 8'h08);
    quarter_frame = 1'b0;
    tick = 1'b1;
    cyc(17);
    tick = 1'b0;
    cyc(1);
    check("env_qf_wr_decay", 32'(vol), 14);
    pulse_qf();
    check("env_qf_wr_start", 32'(vol), 15);

    // Length counter
    do_reset();
    write_reg(2'd0, 8'h00);
    write_reg(2'd3, 8'h18);
    check("len2_loaded", 32'(active), 1);
    pulse_hf();
    check("len2_first_hf", 32'(active), 1);
    pulse_hf();
    check("len2_second_hf", 32'(active), 0);
    half_frame = 1'b1;
    write_reg(2'd3, 8'h18);
    half_frame = 1'b0;
    pulse_hf();
    check("len_load_beats_dec", 32'(active), 1);
    pulse_hf();
    check("len_load_then_zero", 32'(active), 0);
    write_reg(2'd0, 8'h20);
    write_reg(2'd3, 8'h18);
    pulse_hf();
    pulse_hf();
    check("len_halt_holds", 32'(active), 1);
    enable = 1'b0;
    cyc(1);
    check("len_disable", 32'(active), 0);
    write_reg(2'd3, 8'h08);
    check("len_disable_blocks_load", 32'(active), 0);
    enable = 1'b1;

    // Timer wrap coinciding with a reg3 write leaves the step at 0
    do_reset();
    write_reg(2'd0, 8'h3F);
    write_reg(2'd2, 8'h10);
    tick = 1'b1;
    write_reg(2'd3, 8'h08);
    tick = 1'b0;
    cyc(1);
    check("wrap_vs_reg3_step0", 32'(vol), 0);

    // Low-period mute boundary
    do_reset();
    write_reg(2'd0, 8'h3F);
    write_reg(2'd2, 8'h05);
    write_reg(2'd3, 8'h08);
    one_tick();
    check("mute_period5", 32'(vol), 0);
    write_reg(2'd2, 8'h07);
    cyc(1);
    check("mute_period7", 32'(vol), 0);
    write_reg(2'd2, 8'h08);
    cyc(1);
    check("play_period8", 32'(vol), 15);

    // Maximum period with an overflowing sweep setting
`ifdef PULSE_SWEEP_EN
    exp_v = 4'd0;
`else
    exp_v = 4'd15;
`endif
    do_reset();
    write_reg(2'd0, 8'h3F);
    write_reg(2'd1, 8'h81);
    write_reg(2'd2, 8'hFF);
    write_reg(2'd3, 8'h0F);
    one_tick();
    check("period_7ff", 32'(vol), 32'(exp_v));

    // Negate sweep from period 16, shift 1: 7 (ones') mutes, 8 (two's) plays
`ifdef PULSE_SWEEP_EN
    exp_v = (CHANNEL == 0) ? 4'd0 : 4'd15;
`else
    exp_v = 4'd15;
`endif
    do_reset();
    write_reg(2'd0, 8'h3F);
    write_reg(2'd2, 8'h10);
    write_reg(2'd3, 8'h08);
    one_tick();
    check("sweep_pre", 32'(vol), 15);
    write_reg(2'd1, 8'h89);
    pulse_hf();
    check("sweep_negate", 32'(vol), 32'(exp_v));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_channel.md
PULSE_CHANNEL -- requirements
Module: pulse_channel

Interface
REQ-001 Parameter CHANNEL, default 0, sweep negate mode: 0 = ones'-complement (target = period - delta - 1), 1 = two's-complement (target = period - delta).
REQ-002 Parameter OUT_W, default 4, output width; the 4-bit volume is zero-extended when OUT_W > 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 tick  input  1  timer clock-enable, one cycle wide.
REQ-006 quarter_frame  input  1  envelope strobe, one cycle wide.
REQ-007 half_frame  input  1  length/sweep strobe, one cycle wide.
REQ-008 wr_en  input  1  register write strobe.
REQ-009 wr_addr  input  2  register select 0..3.
REQ-010 wr_data  input  8  write data.
REQ-011 enable  input  1  channel enable; 0 forces length to 0.
REQ-012 vol  output  OUT_W  registered sample.
REQ-013 active  output  1  high when length counter != 0.

Function
REQ-014 Register fields: reg0 = duty[7:6], halt/loop[5], const[4], V[3:0]; reg1 = sw_en[7], P[6:4], neg[3], shift[2:0]; reg2 = period[7:0]; reg3 = len_idx[7:3], period[10:8].
REQ-015 Timer (11 bits): on tick, if timer == 0 it reloads period and the duty step (3 bits) increments mod 8; otherwise it decrements.
REQ-016 Duty patterns, steps 0..7: duty 0 = 01000000, 1 = 01100000, 2 = 01111000, 3 = 10011111.
REQ-017 A reg3 write shall reset the step to 0, set envelope start, and, if enable = 1, load length from the table (idx 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-018 Envelope on quarter_frame:
- If start: clear start, decay = 15, divider = V.
- Else if divider == 0: divider = V, and decay decrements if > 0, else reloads to 15 if loop = 1.
- Else divider decrements.
REQ-019 Length on half_frame: decrement if length != 0 and halt = 0; enable = 0 holds length at 0 every cycle.
REQ-020 Sweep: delta = period >> shift; target = period + delta when neg = 0, otherwise per CHANNEL; target is computed 12 bits wide.
REQ-021 Sweep mute: period < 8 or target > 0x7FF, evaluated continuously.
REQ-022 Sweep on half_frame:
- If divider == 0 and sw_en and shift != 0 and not mute: period = target[10:0].
- If divider == 0 or reload: divider = P and reload is cleared; else divider decrements.
- A reg1 write sets reload.
REQ-023 vol is updated every cycle with one-cycle latency: 0 if mute, length == 0, or duty bit == 0; otherwise V when const = 1, else decay.
REQ-024 Simultaneous events:
- A register write to period bits overrides a sweep update in the same cycle.
- A length load overrides a same-cycle decrement.
- enable = 0 overrides a length load.
- A reg3 write on a quarter_frame cycle sets start (it is not consumed that cycle).
REQ-025 A timer wrap with a same-cycle reg3 write shall leave the step at 0.

Reset
REQ-026 rst_n low shall asynchronously clear all registers, timer, step, length, envelope (start, divider, decay), and sweep (divider, reload); vol = 0 and active = 0.
REQ-027 A reset asserted mid-operation shall abort all state; after release the block is idle until written.

Configuration
REQ-028 Macro PULSE_SWEEP_EN:
- Defined: the sweep unit is present as specified in REQ-020 to REQ-022.
- Undefined: there is no sweep divider or period modification, reg1 writes are ignored, and mute = (period < 8) only.

Verification
REQ-029 reg0 = 0xBF, reg2 = 0x10, reg3 = 0x08, enable = 1, tick every cycle -> vol toggles 15 on steps 1..4 (duty 2), each step lasting 17 ticks; active = 1.
REQ-030 reg0 = 0x00, reg3 = 0x08, 16 quarter_frames -> decay 15, 14, ..., 0, then holds at 0; with reg0 = 0x20 it wraps back to 15.
REQ-031 reg3 = 0x18 (len 2), halt = 0, two half_frames -> active falls after the second; with enable = 0, active = 0 the next cycle.
REQ-032 period = 0x100, reg1 = 0x89 (P = 0, neg, shift 1), half_frame -> period becomes 0x7F with CHANNEL = 0, or 0x80 with CHANNEL = 1.
REQ-033 period = 0x7FF, reg1 = 0x81 -> vol = 0 (mute); period = 0x005 -> vol = 0; without PULSE_SWEEP_EN, 0x7FF plays.
REQ-034 Assert rst_n low mid-tone -> vol = 0 and active = 0 immediately, without waiting for a clock edge.
